prog_rom: RTL and testbench
===========================

# prog_rom

Parametrised, loadable program memory: the successor to the fixed combinational instruction ROM of the one-cycle CPU. It holds DEPTH instruction words, serves fetches with a registered one-cycle read, and can be rewritten at run time through a valid/ready load stream. After reset, an init sweep fills every location with the `RST` instruction word, so unloaded or out-of-range addresses always fetch `RST`. It sits between the PC/fetch logic and an external boot loader (UART or debug port).

## Interface
- AWIDTH, 8: address width.
- DWIDTH, 13: instruction word width (5-bit opcode + 8-bit operand).
- DEPTH, 2**AWIDTH: number of implemented words; must satisfy 1 ≤ DEPTH ≤ 2**AWIDTH.
- FILL, `RST`: word written by the init sweep and returned for out-of-range reads.

- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset; synchronous, active-low.
- ADDR  in  AWIDTH  fetch address.
- RD_EN  in  1  fetch request.
- DATA  out  DWIDTH  fetched word, registered.
- DATA_VLD  out  1  DATA holds the result of a fetch accepted in the previous cycle.
- BUSY  out  1  high in the INIT and LOAD states; fetches are ignored while BUSY is high.
- LD_START  in  1  request to enter load mode.
- LD_BASE  in  AWIDTH  first write address, sampled when LD_START is accepted.
- LD_VALID  in  1  LD_DATA is valid.
- LD_READY  out  1  high only in the LOAD state.
- LD_DATA  in  DWIDTH  word to write.
- LD_LAST  in  1  qualifies the final word of a load.
- LD_ERR  out  1  sticky overflow flag; cleared when the next LD_START is accepted.

## Operation
- States: INIT → IDLE ⇄ LOAD.
- INIT:
  - Entered on reset. A sweep counter writes FILL to addresses 0..DEPTH-1, one per cycle.
  - After the write to DEPTH-1, the state moves to IDLE.
  - BUSY=1 and LD_READY=0; LD_START is ignored, not queued.
- IDLE:
  - When RD_EN=1, DATA is set to mem[ADDR] on the next edge, or to FILL if ADDR ≥ DEPTH, and DATA_VLD is set to 1.
  - When RD_EN=0, DATA_VLD goes to 0 and DATA holds its value.
  - When LD_START=1, the block captures LD_BASE into the write pointer, clears LD_ERR and moves to LOAD. A fetch in the same cycle is still served.
- LOAD:
  - A word transfers when LD_VALID && LD_READY.
  - If wptr < DEPTH, the word is written to mem[wptr] and wptr increments.
  - If wptr ≥ DEPTH, including a LD_BASE that was already out of range, the word is dropped and LD_ERR is set to 1.
  - wptr never wraps. It is AWIDTH+1 bits wide internally.
  - A transfer with LD_LAST=1 is written (or dropped) as above, and the state moves to IDLE.
  - Fetches are ignored; DATA_VLD=0 and DATA holds its value.
  - LD_START in this state is ignored.
- Reset mid-operation, in any state, returns the block to INIT; contents are lost and refilled with FILL.

## Timing
- Reset values (in the cycle after RST_N is sampled low):
  - DATA=FILL, DATA_VLD=0, BUSY=1, LD_READY=0, LD_ERR=0.
  - State=INIT, sweep counter=0.
- INIT takes exactly DEPTH cycles. BUSY falls on the edge after the write to DEPTH-1.
- Read latency is 1 cycle from an accepted RD_EN to DATA/DATA_VLD.
- A word written in LOAD is readable from the first IDLE cycle.
- The LD_LAST transfer edge moves the state to IDLE. BUSY and LD_READY fall with it.
- LD_READY rises on the edge that accepts LD_START. Its earliest transfer is the following cycle.
- Throughput is one load word per cycle; there are no wait states.

## Structure
- Shared package: DWIDTH, the opcode width, and the state encoding (INIT/IDLE/LOAD).
  - The opcode macros stay in the existing instruction-set include; FILL defaults to `RST` from it.
- One natural sub-module: prog_rom_ram, a single-port synchronous RAM (DEPTH × DWIDTH) with a registered read and one write port.
  - The FSM muxes the write address/data between the sweep counter and wptr.
- The read and write ports are never active in the same cycle, so there is no read-during-write hazard.

## Test plan
- Reset, then run with DEPTH=16:
  - BUSY=1 for 16 cycles, then 0.
  - Fetches of 0x00..0x0F all return `RST`.
  - A fetch of 0x20 returns `RST`.
- Load with LD_BASE=0x03 and words {`LD`,0xAE}, {`INC`,0x00}, {`JMP`,0x03}, last on the third word:
  - Fetches of 0x03/0x04/0x05 return those words with 1-cycle latency.
  - 0x02 still returns `RST`.
- Same-cycle LD_START and RD_EN in IDLE:
  - The fetch is returned and DATA_VLD=1.
  - LD_READY=1 in the next cycle.
  - A RD_EN during LOAD gives DATA_VLD=0 with DATA held.
- Overflow with DEPTH=16 and LD_BASE=0x0E, sending 4 words:
  - 0x0E and 0x0F are written, and the other two words are dropped.
  - LD_ERR=1 until the next accepted LD_START.
  - Address 0x00 is unchanged.
- RST_N pulsed low mid-load after 2 words:
  - The block re-enters INIT with BUSY=1 for DEPTH cycles.
  - The loaded addresses read `RST` afterwards.
- LD_VALID gaps (valid pattern 1,0,0,1,1 with LD_LAST on the last word):
  - Exactly 3 words are written to consecutive addresses.
  - The state returns to IDLE in the cycle after the last transfer.

Source files
------------

// File: rtl/prog_rom_pkg.sv
// Shared definitions for the loadable program memory: instruction word
// layout, the opcodes the memory needs to know about, and the FSM encoding.
package prog_rom_pkg;

  // Instruction word: 5-bit opcode followed by an 8-bit operand.
  localparam int OPW    = 5;
  localparam int ARGW   = 8;
  localparam int DWIDTH = OPW + ARGW;

  // Opcode values, kept in line with the CPU instruction set.
  localparam logic [OPW-1:0] OP_RST = 5'h1F;
  localparam logic [OPW-1:0] OP_LD  = 5'h01;
  localparam logic [OPW-1:0] OP_INC = 5'h05;
  localparam logic [OPW-1:0] OP_JMP = 5'h0C;

  // Build an instruction word from its opcode and operand.
  function automatic logic [DWIDTH-1:0] mk_insn(input logic [OPW-1:0] op,
                                                input logic [ARGW-1:0] arg);
    return {op, arg};
  endfunction

  // Word used to fill every location after reset and for out-of-range reads.
  localparam logic [DWIDTH-1:0] RST_WORD = {OP_RST, 8'h00};

  // Controller states: fill sweep, serving fetches, accepting a load stream.
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

endpackage

// File: rtl/prog_rom_ram.sv
// Single-port synchronous RAM with a registered read. A write takes the
// port for that cycle; the read register only updates on a read request,
// so the output holds its last fetched word otherwise.
module prog_rom_ram #(
  parameter int AW    = 4,
  parameter int DW    = 13,
  parameter int DEPTH = 16
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write has priority; the controller never asks for both in one cycle.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_rom.sv
// Loadable program memory. After reset a sweep fills every word with FILL;
// then fetches are served with one cycle of latency, and a valid/ready load
// stream can rewrite a run of words starting at a chosen base address.
module prog_rom #(
  parameter int                AWIDTH = 8,
  parameter int                DWIDTH = prog_rom_pkg::DWIDTH,
  parameter int                DEPTH  = 2 ** AWIDTH,
  parameter logic [DWIDTH-1:0] FILL   = DWIDTH'(prog_rom_pkg::RST_WORD)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [AWIDTH-1:0] ADDR,
  input  logic              RD_EN,
  output logic [DWIDTH-1:0] DATA,
  output logic              DATA_VLD,
  output logic              BUSY,
  input  logic              LD_START,
  input  logic [AWIDTH-1:0] LD_BASE,
  input  logic              LD_VALID,
  output logic              LD_READY,
  input  logic [DWIDTH-1:0] LD_DATA,
  input  logic              LD_LAST,
  output logic              LD_ERR
);
  import prog_rom_pkg::*;

  // RAM address width covers exactly the implemented words.
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointers are one bit wider than ADDR so DEPTH itself is representable
  // and the load pointer can run past the end without wrapping.
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH:0] LAST_W  = (AWIDTH + 1)'(DEPTH - 1);
  localparam logic [AWIDTH:0] ONE_W   = (AWIDTH + 1)'(1);

  state_e            state_q, state_d;
  logic [AWIDTH:0]   sweep_q, sweep_d;
  logic [AWIDTH:0]   wptr_q, wptr_d;
  logic              ld_err_q, ld_err_d;
  logic              data_vld_q, data_vld_d;
  // Selects the RAM read register for DATA; when clear, DATA shows FILL.
  logic              sel_ram_q, sel_ram_d;

  logic              addr_in_range;
  logic              wptr_in_range;
  logic              ram_we;
  logic              ram_re;
  logic [RAM_AW-1:0] ram_addr;
  logic [DWIDTH-1:0] ram_wdata;
  logic [DWIDTH-1:0] ram_rdata;

  assign addr_in_range = ({1'b0, ADDR} < DEPTH_W);
  assign wptr_in_range = (wptr_q < DEPTH_W);

  prog_rom_ram #(
    .AW    (RAM_AW),
    .DW    (DWIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (CLK),
    .addr_i  (ram_addr),
    .we_i    (ram_we),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .rdata_o (ram_rdata)
  );

  // Next-state logic and RAM port steering (sweep, load pointer or fetch).
  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    wptr_d     = wptr_q;
    ld_err_d   = ld_err_q;
    data_vld_d = 1'b0;
    sel_ram_d  = sel_ram_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = FILL;

    unique case (state_q)
      ST_INIT: begin
        ram_we    = 1'b1;
        ram_addr  = sweep_q[RAM_AW-1:0];
        ram_wdata = FILL;
        sweep_d   = sweep_q + ONE_W;
        if (sweep_q == LAST_W) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (RD_EN) begin
          data_vld_d = 1'b1;
          sel_ram_d  = addr_in_range;
          ram_re     = addr_in_range;
          ram_addr   = ADDR[RAM_AW-1:0];
        end
        if (LD_START) begin
          wptr_d   = {1'b0, LD_BASE};
          ld_err_d = 1'b0;
          state_d  = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (LD_VALID) begin
          if (wptr_in_range) begin
            ram_we    = 1'b1;
            ram_addr  = wptr_q[RAM_AW-1:0];
            ram_wdata = LD_DATA;
            wptr_d    = wptr_q + ONE_W;
          end else begin
            ld_err_d = 1'b1;
          end
          if (LD_LAST) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_INIT;
        sweep_d = '0;
      end
    endcase
  end

  // State registers; reset restarts the fill sweep from address zero.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= ST_INIT;
      sweep_q    <= '0;
      wptr_q     <= '0;
      ld_err_q   <= 1'b0;
      data_vld_q <= 1'b0;
      sel_ram_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      wptr_q     <= wptr_d;
      ld_err_q   <= ld_err_d;
      data_vld_q <= data_vld_d;
      sel_ram_q  <= sel_ram_d;
    end
  end

  assign DATA     = sel_ram_q ? ram_rdata : FILL;
  assign DATA_VLD = data_vld_q;
  assign BUSY     = (state_q != ST_IDLE);
  assign LD_READY = (state_q == ST_LOAD);
  assign LD_ERR   = ld_err_q;

endmodule

// File: tb/tb_prog_rom.sv
// Directed-plus-random bench for prog_rom (DEPTH=16). A plain array holds
// the expected memory contents; loads update it word by word from the
// base address, dropping anything at or beyond DEPTH.
module tb_prog_rom;
  import prog_rom_pkg::*;

  localparam int AW  = 8;
  localparam int DW  = 13;
  localparam int DEP = 16;
  localparam logic [DW-1:0] FILLW = RST_WORD;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic          rd_en;
  logic [DW-1:0] data;
  logic          data_vld;
  logic          busy;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic          ld_valid;
  logic          ld_ready;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mdl [DEP];
  logic [DW-1:0] wq [$];

  prog_rom #(
    .AWIDTH (AW),
    .DWIDTH (DW),
    .DEPTH  (DEP)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .ADDR     (addr),
    .RD_EN    (rd_en),
    .DATA     (data),
    .DATA_VLD (data_vld),
    .BUSY     (busy),
    .LD_START (ld_start),
    .LD_BASE  (ld_base),
    .LD_VALID (ld_valid),
    .LD_READY (ld_ready),
    .LD_DATA  (ld_data),
    .LD_LAST  (ld_last),
    .LD_ERR   (ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected fetch result for an address under the model.
  function automatic logic [DW-1:0] expect_word(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    r = FILLW;
    if (int'(a) < DEP) r = mdl[a[3:0]];
    return r;
  endfunction

  // Fetch one address, then idle a cycle and confirm DATA holds.
  task automatic fetch(input logic [AW-1:0] a);
    logic [DW-1:0] exp;
    exp   = expect_word(a);
    addr  = a;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("fetch_data", 32'(data), 32'(exp));
    chk("fetch_vld", 32'(data_vld), 32'd1);
    $display("fetch addr=%02h data=%04h", a, data);
    addr = AW'($urandom);
    tick();
    chk("hold_vld", 32'(data_vld), 32'd0);
    chk("hold_data", 32'(data), 32'(exp));
  endtask

  // Reset, then time the fill sweep while poking fetches and load starts.
  task automatic reset_and_init();
    int n;
    rst_n    = 1'b0;
    rd_en    = 1'b0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    tick();
    tick();
    chk("rst_data", 32'(data), 32'(FILLW));
    chk("rst_vld", 32'(data_vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ready", 32'(ld_ready), 32'd0);
    chk("rst_err", 32'(ld_err), 32'd0);
    rst_n    = 1'b1;
    rd_en    = 1'b1;
    ld_start = 1'b1;
    ld_base  = 8'h05;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      addr = AW'($urandom);
      tick();
      n++;
      chk("init_vld", 32'(data_vld), 32'd0);
    end
    chk("init_len", 32'(n), 32'(DEP));
    chk("init_ready", 32'(ld_ready), 32'd0);
    rd_en    = 1'b0;
    ld_start = 1'b0;
    for (int i = 0; i < DEP; i++) mdl[i] = FILLW;
    $display("reset: init sweep took %0d cycles", n);
  endtask

  // Load stream: vpat[c] gives LD_VALID for cycle c; LD_LAST on the final
  // cycle, which must be a valid one. Words come from wq, else random.
  task automatic load(input logic [AW-1:0] base, input int ncyc, input logic [15:0] vpat);
    int ptr;
    int nw;
    logic [DW-1:0] w;
    logic err;
    ld_base  = base;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk("ld_ready_rise", 32'(ld_ready), 32'd1);
    chk("ld_err_clr", 32'(ld_err), 32'd0);
    ptr = int'(base);
    err = 1'b0;
    nw  = 0;
    for (int c = 0; c < ncyc; c++) begin
      ld_valid = vpat[c];
      ld_last  = (c == ncyc - 1);
      if (vpat[c]) begin
        w = (wq.size() > 0) ? wq.pop_front() : DW'($urandom);
        ld_data = w;
        if (ptr < DEP) mdl[ptr] = w;
        else err = 1'b1;
        ptr++;
        nw++;
      end else begin
        ld_data = DW'($urandom);
      end
      tick();
      if (c < ncyc - 1) chk("ld_ready_hold", 32'(ld_ready), 32'd1);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("ld_done_busy", 32'(busy), 32'd0);
    chk("ld_done_ready", 32'(ld_ready), 32'd0);
    chk("ld_err", 32'(ld_err), 32'(err));
    $display("load base=%02h words=%0d err=%0b", base, nw, ld_err);
  endtask

  initial begin
    logic [DW-1:0] w;
    int base;
    int n;
    rst_n = 1'b0; addr = '0; rd_en = 1'b0; ld_start = 1'b0; ld_base = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;

    // Reset and fill; everything in and out of range reads RST.
    reset_and_init();
    for (int a = 0; a < DEP; a++) fetch(AW'(a));
    fetch(8'h20);
    fetch(8'hFF);

    // Directed program load at 0x03.
    wq.push_back(mk_insn(OP_LD, 8'hAE));
    wq.push_back(mk_insn(OP_INC, 8'h00));
    wq.push_back(mk_insn(OP_JMP, 8'h03));
    load(8'h03, 3, 16'h0007);
    fetch(8'h03);
    fetch(8'h04);
    fetch(8'h05);
    fetch(8'h02);

    // Fetch and LD_START together; LOAD ignores fetches and LD_START.
    addr = 8'h04; rd_en = 1'b1; ld_start = 1'b1; ld_base = 8'h08;
    tick();
    chk("same_data", 32'(data), 32'(mdl[4]));
    chk("same_vld", 32'(data_vld), 32'd1);
    chk("same_ready", 32'(ld_ready), 32'd1);
    addr = 8'h05; rd_en = 1'b1; ld_start = 1'b1; ld_base = 8'h00; ld_valid = 1'b0;
    tick();
    chk("load_rd_vld", 32'(data_vld), 32'd0);
    chk("load_rd_hold", 32'(data), 32'(mdl[4]));
    rd_en = 1'b0; ld_start = 1'b0;
    w = DW'($urandom);
    ld_valid = 1'b1; ld_last = 1'b1; ld_data = w;
    tick();
    mdl[8] = w;
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("single_busy", 32'(busy), 32'd0);
    $display("load base=08 words=1 (with same-cycle fetch)");
    fetch(8'h08);
    fetch(8'h00);

    // Overflow off the top, then a base already out of range.
    load(8'h0E, 4, 16'h000F);
    fetch(8'h0E);
    fetch(8'h0F);
    fetch(8'h00);
    chk("err_sticky", 32'(ld_err), 32'd1);
    load(8'h40, 2, 16'h0003);
    load(8'h00, 1, 16'h0001);
    fetch(8'h00);

    // Random loads, then sweep every address.
    for (int k = 0; k < 5; k++) begin
      base = $urandom_range(0, DEP - 1);
      n    = $urandom_range(1, 5);
      load(AW'(base), n, 16'((1 << n) - 1));
    end
    for (int a = 0; a < DEP; a++) fetch(AW'(a));
    fetch(AW'($urandom_range(DEP, 255)));

    // Reset in the middle of a load after two words.
    ld_base = 8'h09; ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      ld_valid = 1'b1; ld_last = 1'b0; ld_data = DW'($urandom);
      tick();
    end
    ld_valid = 1'b0;
    $display("load base=09 interrupted by reset after 2 words");
    reset_and_init();
    fetch(8'h09);
    fetch(8'h0A);
    fetch(8'h03);

    // Gapped valid pattern 1,0,0,1,1 at base 0x06.
    load(8'h06, 5, 16'b11001);
    for (int a = 5; a <= 10; a++) fetch(AW'(a));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
